// File: rtl/run_controller.sv
// rtl/run_controller.sv - execution pacing controller: single step, burst, free run, breakpoint and halt
//
// Ports:
//   clock        single clock, all state changes on its rising edge
//   reset        asynchronous active-high reset
//   tick         one-cycle rate strobe pacing RUN/BURST advances
//   mode_run     level, free-run requested
//   step         debounced level, rising edge requests one advance
//   burst_go     one-cycle pulse, starts a burst of burst_len advances
//   burst_len    burst length, sampled on burst_go
//   resume       one-cycle pulse, leaves BREAK
//   halt_req     level, datapath requests a permanent stop
//   bp_en/bp_pc  breakpoint enable and address
//   pc           current datapath program counter
//   cpu_en       registered, one pipeline advance per high cycle
//   state        IDLE=0 STEP=1 BURST=2 RUN=3 BREAK=4 HALT=5
//   cycles_left  remaining burst advances
//   adv_count    wrapping count of issued advances
//   bp_hit       breakpoint stop flag
//   halted       permanent stop flag
module run_controller #(
  parameter int PC_W    = 16,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               mode_run,
  input  logic               step,
  input  logic               burst_go,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               resume,
  input  logic               halt_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_pc,
  input  logic [PC_W-1:0]    pc,
  output logic               cpu_en,
  output logic [2:0]         state,
  output logic [BURST_W-1:0] cycles_left,
  output logic [15:0]        adv_count,
  output logic               bp_hit,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_BURST = 3'd2,
    S_RUN   = 3'd3,
    S_BREAK = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t             cur;
  state_t             nxt;
  logic               cpu_en_n;
  logic [BURST_W-1:0] cycles_n;
  logic               bp_hit_n;
  logic               halted_n;
  logic               skip;
  logic               skip_n;
  logic               step_prev;
  logic               step_edge;
  logic               bp_match;

  assign step_edge = step & ~step_prev;
  // The skip flag lets the first advance after a resume leave the breakpoint address.
  assign bp_match  = bp_en & (pc == bp_pc) & ~skip;
  assign state     = cur;

  always_comb begin
    nxt      = cur;
    cpu_en_n = 1'b0;
    cycles_n = cycles_left;
    bp_hit_n = bp_hit;
    halted_n = halted;
    skip_n   = skip;

    if (cur != S_HALT && halt_req) begin
      nxt      = S_HALT;
      halted_n = 1'b1;
    end else begin
      unique case (cur)
        S_IDLE: begin
          if (step_edge) begin
            nxt      = S_STEP;
            cpu_en_n = 1'b1;
          end else if (burst_go && burst_len != '0) begin
            nxt      = S_BURST;
            cycles_n = burst_len;
          end else if (mode_run) begin
            nxt = S_RUN;
          end
        end
        S_STEP: begin
          nxt = S_IDLE;
        end
        S_BURST: begin
          if (tick) begin
            if (bp_match) begin
              nxt      = S_BREAK;
              bp_hit_n = 1'b1;
            end else begin
              cpu_en_n = 1'b1;
              cycles_n = cycles_left - 1'b1;
              // Last advance of the burst leaves on the same edge it issues.
              if (cycles_left == {{(BURST_W-1){1'b0}}, 1'b1}) nxt = S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (!mode_run) begin
            nxt = S_IDLE;
          end else if (tick) begin
            if (bp_match) begin
              nxt      = S_BREAK;
              bp_hit_n = 1'b1;
            end else begin
              cpu_en_n = 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (resume) begin
            nxt      = S_IDLE;
            bp_hit_n = 1'b0;
            skip_n   = 1'b1;
          end
        end
        S_HALT: begin
          nxt = S_HALT;
        end
        default: begin
          nxt = S_IDLE;
        end
      endcase
    end

    // Any issued advance consumes the one-shot breakpoint suppression.
    if (cpu_en_n) skip_n = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur         <= S_IDLE;
      cpu_en      <= 1'b0;
      cycles_left <= '0;
      adv_count   <= 16'h0000;
      bp_hit      <= 1'b0;
      halted      <= 1'b0;
      skip        <= 1'b0;
      step_prev   <= 1'b0;
    end else begin
      cur         <= nxt;
      cpu_en      <= cpu_en_n;
      cycles_left <= cycles_n;
      bp_hit      <= bp_hit_n;
      halted      <= halted_n;
      skip        <= skip_n;
      step_prev   <= step;
      if (cpu_en_n) adv_count <= adv_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - scoreboard testbench for run_controller
module tb_run_controller;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        mode_run;
  logic        step;
  logic        burst_go;
  logic [7:0]  burst_len;
  logic        resume;
  logic        halt_req;
  logic        bp_en;
  logic [15:0] bp_pc;
  logic [15:0] pc;
  logic        cpu_en;
  logic [2:0]  state;
  logic [7:0]  cycles_left;
  logic [15:0] adv_count;
  logic        bp_hit;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int exp_adv = 0;
  int obs_rd = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  run_controller #(.PC_W(16), .BURST_W(8)) dut (
    .clock(clock), .reset(reset), .tick(tick), .mode_run(mode_run), .step(step),
    .burst_go(burst_go), .burst_len(burst_len), .resume(resume), .halt_req(halt_req),
    .bp_en(bp_en), .bp_pc(bp_pc), .pc(pc), .cpu_en(cpu_en), .state(state),
    .cycles_left(cycles_left), .adv_count(adv_count), .bp_hit(bp_hit), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Records the advance number carried by every observed cpu_en cycle.
  always @(posedge clock) begin
    #1;
    if (cpu_en === 1'b1) obs_q.push_back(adv_count);
  end

  task automatic tk();
    @(posedge clock);
    #1;
  endtask

  task automatic push_adv();
    exp_adv = exp_adv + 1;
    exp_q.push_back(16'(exp_adv));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tk();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %0b exp 0", cpu_en); end
    checks++; if (cycles_left !== 8'd0) begin errors++; $display("FAIL reset_cycles_left got %0d exp 0", cycles_left); end
    checks++; if (adv_count !== 16'd0) begin errors++; $display("FAIL reset_adv_count got %0d exp 0", adv_count); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit got %0b exp 0", bp_hit); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    reset = 1'b0;
    tk();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", state); end
  endtask

  task automatic test_step();
    int pulses = 0;
    step = 1'b1;
    push_adv();
    for (int i = 0; i < 10; i++) begin
      tk();
      if (cpu_en === 1'b1) pulses++;
      if (i == 0) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL step_state1 got %0d exp 1", state); end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_cpu_en got %0b exp 1", cpu_en); end
      end
      if (i == 1) begin
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL step_return got %0d exp 0", state); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulses got %0d exp 1", pulses); end
    checks++; if (adv_count !== 16'(exp_adv)) begin errors++; $display("FAIL step_adv got %0d exp %0d", adv_count, exp_adv); end
    step = 1'b0;
    tk();
    while (exp_q.size() > 0) begin
      logic [15:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL step_sb_missing got none exp %0d", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL step_sb got %0d exp %0d", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin errors++; $display("FAIL step_sb_extra got %0d exp %0d", obs_q.size(), obs_rd); end
  endtask

  task automatic test_burst();
    int pulses = 0;
    int k = 0;
    bit t;
    burst_len = 8'd0;
    burst_go = 1'b1;
    tk();
    burst_go = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL burst_zero_state got %0d exp 0", state); end
    checks++; if (cycles_left !== 8'd0) begin errors++; $display("FAIL burst_zero_cycles got %0d exp 0", cycles_left); end
    burst_len = 8'd3;
    burst_go = 1'b1;
    tk();
    burst_go = 1'b0;
    burst_len = 8'd0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL burst_state got %0d exp 2", state); end
    checks++; if (cycles_left !== 8'd3) begin errors++; $display("FAIL burst_cycles0 got %0d exp 3", cycles_left); end
    step = 1'b1;
    mode_run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t = (i % 4 == 3);
      tick = t;
      if (i == 5) burst_go = 1'b1;
      if (t) push_adv();
      tk();
      tick = 1'b0;
      burst_go = 1'b0;
      if (cpu_en === 1'b1) pulses++;
      if (t) begin
        k++;
        checks++; if (cycles_left !== 8'(3 - k)) begin errors++; $display("FAIL burst_cycles got %0d exp %0d", cycles_left, 3 - k); end
      end
    end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL burst_end_state got %0d exp 0", state); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL burst_pulses got %0d exp 3", pulses); end
    checks++; if (adv_count !== 16'(exp_adv)) begin errors++; $display("FAIL burst_adv got %0d exp %0d", adv_count, exp_adv); end
    step = 1'b0;
    tk();
    while (exp_q.size() > 0) begin
      logic [15:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL burst_sb_missing got none exp %0d", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL burst_sb got %0d exp %0d", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin errors++; $display("FAIL burst_sb_extra got %0d exp %0d", obs_q.size(), obs_rd); end
  endtask

  task automatic test_breakpoint();
    int pulses = 0;
    pc = 16'd2;
    bp_pc = 16'h0005;
    bp_en = 1'b1;
    mode_run = 1'b1;
    tick = 1'b1;
    tk();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL bp_run_state got %0d exp 3", state); end
    for (int i = 0; i < 3; i++) push_adv();
    for (int i = 0; i < 20; i++) begin
      tk();
      if (cpu_en === 1'b1) begin pulses++; pc = (pc == 16'd7) ? 16'd2 : pc + 16'd1; end
      if (state === 3'd4) break;
    end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL bp_break_state got %0d exp 4", state); end
    checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit got %0b exp 1", bp_hit); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL bp_cpu_en got %0b exp 0", cpu_en); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL bp_pulses1 got %0d exp 3", pulses); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tk();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++; if (state !== 3'd4 || pulses != 0) begin errors++; $display("FAIL bp_hold got state %0d pulses %0d exp 4 0", state, pulses); end
    resume = 1'b1;
    tk();
    resume = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL bp_resume_state got %0d exp 0", state); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_resume_hit got %0b exp 0", bp_hit); end
    for (int i = 0; i < 6; i++) push_adv();
    for (int i = 0; i < 30; i++) begin
      tk();
      if (cpu_en === 1'b1) begin pulses++; pc = (pc == 16'd7) ? 16'd2 : pc + 16'd1; end
      if (state === 3'd4) break;
    end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL bp_rehit_state got %0d exp 4", state); end
    checks++; if (pulses != 6) begin errors++; $display("FAIL bp_pulses2 got %0d exp 6", pulses); end
    checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL bp_rehit_pc got %0h exp 5", pc); end
    mode_run = 1'b0;
    bp_en = 1'b0;
    resume = 1'b1;
    tk();
    resume = 1'b0;
    tick = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL bp_exit_state got %0d exp 0", state); end
    mode_run = 1'b1;
    tk();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL run_enter got %0d exp 3", state); end
    mode_run = 1'b0;
    tick = 1'b1;
    tk();
    tick = 1'b0;
    checks++; if (state !== 3'd0 || cpu_en !== 1'b0) begin errors++; $display("FAIL run_exit got state %0d cpu_en %0b exp 0 0", state, cpu_en); end
    tk();
    while (exp_q.size() > 0) begin
      logic [15:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL bp_sb_missing got none exp %0d", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL bp_sb got %0d exp %0d", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin errors++; $display("FAIL bp_sb_extra got %0d exp %0d", obs_q.size(), obs_rd); end
  endtask

  task automatic test_halt();
    int pulses = 0;
    mode_run = 1'b1;
    tk();
    halt_req = 1'b1;
    tick = 1'b1;
    tk();
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL halt_state got %0d exp 5", state); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0b exp 1", halted); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_cpu_en got %0b exp 0", cpu_en); end
    halt_req = 1'b0;
    mode_run = 1'b0;
    burst_len = 8'd4;
    for (int i = 0; i < 8; i++) begin
      step = (i % 2 == 0);
      burst_go = (i == 3);
      mode_run = (i > 4);
      resume = (i == 6);
      tk();
      if (cpu_en === 1'b1) pulses++;
    end
    step = 1'b0; burst_go = 1'b0; mode_run = 1'b0; resume = 1'b0; tick = 1'b0; burst_len = 8'd0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL halt_pulses got %0d exp 0", pulses); end
    checks++; if (state !== 3'd5 || halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got state %0d halted %0b exp 5 1", state, halted); end
    reset = 1'b1;
    tk();
    reset = 1'b0;
    exp_adv = 0;
    tk();
    checks++; if (state !== 3'd0 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset got state %0d halted %0b exp 0 0", state, halted); end
  endtask

  task automatic test_reset_mid_burst();
    int pulses = 0;
    burst_len = 8'd5;
    burst_go = 1'b1;
    tk();
    burst_go = 1'b0;
    burst_len = 8'd0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) push_adv();
    for (int i = 0; i < 3; i++) tk();
    checks++; if (cycles_left !== 8'd2) begin errors++; $display("FAIL rstb_cycles got %0d exp 2", cycles_left); end
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL rstb_cpu_en_pre got %0b exp 1", cpu_en); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || cpu_en !== 1'b0 || cycles_left !== 8'd0) begin
      errors++; $display("FAIL rstb_async got state %0d cpu_en %0b cycles %0d exp 0 0 0", state, cpu_en, cycles_left); end
    checks++; if (adv_count !== 16'd0 || bp_hit !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL rstb_async_flags got adv %0d bp %0b halted %0b exp 0 0 0", adv_count, bp_hit, halted); end
    tk();
    tk();
    reset = 1'b0;
    exp_adv = 0;
    for (int i = 0; i < 10; i++) begin
      tk();
      if (cpu_en === 1'b1) pulses++;
    end
    tick = 1'b0;
    checks++; if (pulses != 0 || state !== 3'd0) begin errors++; $display("FAIL rstb_release got pulses %0d state %0d exp 0 0", pulses, state); end
    while (exp_q.size() > 0) begin
      logic [15:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin errors++; $display("FAIL rstb_sb_missing got none exp %0d", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin errors++; $display("FAIL rstb_sb got %0d exp %0d", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin errors++; $display("FAIL rstb_sb_extra got %0d exp %0d", obs_q.size(), obs_rd); end
  endtask

  task automatic test_wrap();
    int seen = 0;
    int n = 0;
    bp_en = 1'b0;
    mode_run = 1'b1;
    tick = 1'b1;
    tk();
    while (seen < 65535 && n < 70000) begin
      tk();
      n++;
      if (cpu_en === 1'b1) seen++;
    end
    checks++; if (seen != 65535) begin errors++; $display("FAIL wrap_budget got %0d exp 65535", seen); end
    checks++; if (adv_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %0h exp ffff", adv_count); end
    tk();
    checks++; if (cpu_en !== 1'b1 || adv_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got cpu_en %0b adv %0h exp 1 0", cpu_en, adv_count); end
    mode_run = 1'b0;
    tick = 1'b0;
    tk();
    obs_rd = obs_q.size();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; mode_run = 1'b0; step = 1'b0; burst_go = 1'b0;
    burst_len = 8'd0; resume = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
    bp_pc = 16'd0; pc = 16'd0;
    test_reset();
    test_step();
    test_burst();
    test_breakpoint();
    test_halt();
    test_reset_mid_burst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
